// File: rtl/pipe_stage_reg.sv
// Pipeline stage register: control/data entry with valid/ready handshake, stall, flush and bubbles.
// Define PIPE_SKID_EN for a second skid entry and a registered in_ready.
module pipe_stage_reg #(
  parameter int CTRLW = 8,
  parameter int DATAW = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             nop,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_nop,
  input  logic [CTRLW-1:0] in_ctrl,
  input  logic [DATAW-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_nop,
  output logic [CTRLW-1:0] out_ctrl,
  output logic [DATAW-1:0] out_data
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } state_t;

  state_t r_state;
  state_t w_stateNext;

  logic             r_outNop;
  logic [CTRLW-1:0] r_outCtrl;
  logic [DATAW-1:0] r_outData;

  logic             w_accept;
  logic             w_present;
  logic             w_entryNop;
  logic [CTRLW-1:0] w_entryCtrl;
  logic             w_loadOut;
  logic             w_clearOut;

  // A bubble keeps its data but can never cause side effects downstream.
  assign w_entryNop  = nop | in_nop;
  assign w_entryCtrl = w_entryNop ? '0 : in_ctrl;

  assign w_accept  = in_valid & in_ready;
  assign w_present = out_valid & out_ready;

  assign out_valid = (r_state != ST_EMPTY);
  assign out_nop   = r_outNop;
  assign out_ctrl  = r_outCtrl;
  assign out_data  = r_outData;

`ifdef PIPE_SKID_EN
  logic             r_inReady;
  logic             r_skidNop;
  logic [CTRLW-1:0] r_skidCtrl;
  logic [DATAW-1:0] r_skidData;
  logic             w_loadSkid;
  logic             w_moveSkid;

  assign in_ready = r_inReady;
`else
  assign in_ready = (r_state == ST_EMPTY) | out_ready;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_stateNext;
    end
  end

  always_comb begin
    w_stateNext = r_state;
    w_loadOut   = 1'b0;
    w_clearOut  = 1'b0;
`ifdef PIPE_SKID_EN
    w_loadSkid  = 1'b0;
    w_moveSkid  = 1'b0;
`endif
    if (flush) begin
      w_stateNext = ST_EMPTY;
      w_clearOut  = 1'b1;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_accept) begin
            w_stateNext = ST_FULL;
            w_loadOut   = 1'b1;
          end
        end
        ST_FULL: begin
          if (w_present && w_accept) begin
            w_loadOut = 1'b1;
          end else if (w_present) begin
            w_stateNext = ST_EMPTY;
            w_clearOut  = 1'b1;
`ifdef PIPE_SKID_EN
          end else if (w_accept) begin
            w_stateNext = ST_SKID;
            w_loadSkid  = 1'b1;
`endif
          end
        end
`ifdef PIPE_SKID_EN
        ST_SKID: begin
          if (w_present) begin
            w_stateNext = ST_FULL;
            w_moveSkid  = 1'b1;
          end
        end
`endif
        default: begin
          w_stateNext = ST_EMPTY;
          w_clearOut  = 1'b1;
        end
      endcase
    end
  end

  // Output register: cleared when it stops holding an entry so out_ctrl is 0 while idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_outNop  <= 1'b0;
      r_outCtrl <= '0;
      r_outData <= '0;
    end else if (w_clearOut) begin
      r_outNop  <= 1'b0;
      r_outCtrl <= '0;
      if (flush) begin
        r_outData <= '0;
      end
    end else if (w_loadOut) begin
      r_outNop  <= w_entryNop;
      r_outCtrl <= w_entryCtrl;
      r_outData <= in_data;
`ifdef PIPE_SKID_EN
    end else if (w_moveSkid) begin
      r_outNop  <= r_skidNop;
      r_outCtrl <= r_skidCtrl;
      r_outData <= r_skidData;
`endif
    end
  end

`ifdef PIPE_SKID_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_skidNop  <= 1'b0;
      r_skidCtrl <= '0;
      r_skidData <= '0;
    end else if (flush) begin
      r_skidNop  <= 1'b0;
      r_skidCtrl <= '0;
      r_skidData <= '0;
    end else if (w_loadSkid) begin
      r_skidNop  <= w_entryNop;
      r_skidCtrl <= w_entryCtrl;
      r_skidData <= in_data;
    end else if (w_moveSkid) begin
      r_skidNop  <= 1'b0;
      r_skidCtrl <= '0;
    end
  end

  // Ready is looked up from the next state so upstream never sees out_ready combinationally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_inReady <= 1'b0;
    end else begin
      r_inReady <= (w_stateNext != ST_SKID);
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: directed steps then random traffic against a FIFO model.
// Works for both the default build and PIPE_SKID_EN.
module tb_pipe_stage_reg;
  localparam int CTRLW = 8;
  localparam int DATAW = 64;
`ifdef PIPE_SKID_EN
  localparam int DEPTH   = 2;
  localparam bit HAS_SKID = 1'b1;
`else
  localparam int DEPTH   = 1;
  localparam bit HAS_SKID = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic             nop;
  logic             in_valid;
  logic             in_ready;
  logic             in_nop;
  logic [CTRLW-1:0] in_ctrl;
  logic [DATAW-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic             out_nop;
  logic [CTRLW-1:0] out_ctrl;
  logic [DATAW-1:0] out_data;

  pipe_stage_reg #(.CTRLW(CTRLW), .DATAW(DATAW)) dut (
    .clk(clk), .rst(rst), .flush(flush), .nop(nop),
    .in_valid(in_valid), .in_ready(in_ready), .in_nop(in_nop),
    .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_nop(out_nop),
    .out_ctrl(out_ctrl), .out_data(out_data)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic             nop;
    logic [CTRLW-1:0] ctrl;
    logic [DATAW-1:0] data;
  } entry_t;

  // Reference: a FIFO of capacity DEPTH; zeroed marks outputs known to be cleared.
  entry_t model[$];
  bit     mReady;
  bit     mZeroed;
  int     checks;
  int     errors;

  function automatic bit expReady();
    if (HAS_SKID) return mReady;
    return (model.size() == 0) || (out_ready == 1'b1);
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput();
    check("out_valid", 64'(out_valid), 64'(model.size() > 0));
    if (model.size() > 0) begin
      check("out_ctrl", 64'(out_ctrl), 64'(model[0].ctrl));
      check("out_nop", 64'(out_nop), 64'(model[0].nop));
      check("out_data", 64'(out_data), 64'(model[0].data));
    end else begin
      check("out_ctrl_idle", 64'(out_ctrl), 64'd0);
      if (mZeroed) begin
        check("out_nop_idle", 64'(out_nop), 64'd0);
        check("out_data_idle", 64'(out_data), 64'd0);
      end
    end
  endtask

  // One clock: drive inputs, check in_ready, step the edge and the model, check outputs.
  task automatic applyStimulus(input logic v, input logic n, input logic inn,
                               input logic [CTRLW-1:0] c, input logic [DATAW-1:0] d,
                               input logic ordy, input logic fl);
    bit     rdy;
    bit     pres;
    entry_t e;
    in_valid  = v;
    nop       = n;
    in_nop    = inn;
    in_ctrl   = c;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    #1;
    rdy = expReady();
    check("in_ready", 64'(in_ready), 64'(rdy));
    @(posedge clk);
    if (fl) begin
      model.delete();
      mZeroed = 1'b1;
    end else begin
      pres = (model.size() > 0) && ordy;
      if (pres) void'(model.pop_front());
      if (v && rdy) begin
        e.nop  = n | inn;
        e.ctrl = (n | inn) ? '0 : c;
        e.data = d;
        model.push_back(e);
        mZeroed = 1'b0;
      end
    end
    mReady = (model.size() < DEPTH);
    #1;
    checkOutput();
  endtask

  task automatic idleInputs();
    in_valid  = 1'b0;
    nop       = 1'b0;
    in_nop    = 1'b0;
    in_ctrl   = '0;
    in_data   = '0;
    out_ready = 1'b0;
    flush     = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    checks  = 0;
    errors  = 0;
    mReady  = 1'b0;
    mZeroed = 1'b1;
    idleInputs();
    rst = 1'b1;
    #2;
    checkOutput();
    check("in_ready_reset", 64'(in_ready), HAS_SKID ? 64'd0 : 64'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;

    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 64'h0, 1'b1, 1'b0);

    // Streaming with out_ready held high.
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h5A, 64'h1234, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h01, 64'h1111, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h02, 64'h2222, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h03, 64'h3333, 1'b1, 1'b0);

    // Stall three cycles with upstream still offering, then release.
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h10, 64'hA0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h20, 64'hB0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h30, 64'hC0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 64'h0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 64'h0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 64'h0, 1'b1, 1'b0);

    // Bubbles from the local nop and from the upstream nop flag.
    applyStimulus(1'b1, 1'b1, 1'b0, 8'hFF, 64'hABCD, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1, 8'hFF, 64'hABCD, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 64'h0, 1'b1, 1'b0);

    // nop during a stall must not touch the held entry.
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h44, 64'h4444, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h55, 64'h5555, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, 64'h0, 1'b0, 1'b0);

    // Flush a full stage while a 0x11 entry is offered.
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h11, 64'h1100, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 64'h0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 64'h0, 1'b1, 1'b0);

    // Asynchronous reset in the middle of a stall.
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h66, 64'h6666, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h77, 64'h7777, 1'b0, 1'b0);
    #2;
    idleInputs();
    rst = 1'b1;
    #1;
    model.delete();
    mReady  = 1'b0;
    mZeroed = 1'b1;
    checkOutput();
    check("in_ready_async_rst", 64'(in_ready), HAS_SKID ? 64'd0 : 64'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h88, 64'h8888, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h99, 64'h9999, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 64'h0, 1'b1, 1'b0);

    // Random traffic with occasional bubbles and flushes.
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(3) != 0),
                    ($urandom_range(7) == 0),
                    ($urandom_range(7) == 0),
                    CTRLW'($urandom),
                    {$urandom, $urandom},
                    ($urandom_range(2) != 0),
                    ($urandom_range(15) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised pipeline stage register, successor to the fixed-field inter-stage latches (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries a control field and a data field between two pipeline stages with valid/ready handshake, stall, flush and bubble insertion.
- Control is zeroed on bubble/flush so the downstream stage has no side effects; the data field passes unmodified.
- Instantiated once per stage boundary in the pipelined CPU, with widths set per boundary.

Parameters:
- CTRLW, 8, control field width in bits (bubble forces this field to 0).
- DATAW, 64, data field width in bits (concatenated opcode/pc/results/rd etc.).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- flush  in  1  drop all held entries this cycle (branch mispredict / exception).
- nop  in  1  stage-local bubble request; forces the stored control field to 0.
- in_valid  in  1  upstream entry present.
- in_ready  out  1  stage can accept this cycle.
- in_nop  in  1  upstream marks entry as bubble (propagated nop).
- in_ctrl  in  CTRLW  control field.
- in_data  in  DATAW  data field.
- out_valid  out  1  entry presented downstream.
- out_ready  in  1  downstream accepts; low = stall.
- out_nop  out  1  presented entry is a bubble.
- out_ctrl  out  CTRLW  control field (0 when out_nop).
- out_data  out  DATAW  data field.

Behaviour:
- Reset: async on rst high. out_valid=0, out_nop=0, out_ctrl=0, out_data=0, and all storage cleared. With PIPE_SKID_EN, in_ready=0 during reset and 1 from the first edge after release. Without it, in_ready=1 (see below).
- Accept: in_valid && in_ready at a rising edge.
- Present: out_valid && out_ready at a rising edge dequeues the head.
- Stored entry:
  - ctrl = (nop || in_nop) ? 0 : in_ctrl.
  - nop flag = nop || in_nop.
  - data = in_data, always.
- Latency: 1 cycle from accept to out_valid when the stage is empty.
- States without the macro:
  - EMPTY: out_valid=0. Accept -> FULL.
  - FULL: out_valid=1. Present with no accept -> EMPTY. Present with accept -> FULL, new entry. Neither -> hold all outputs unchanged (stall).
  - in_ready = !out_valid || out_ready (combinational).
- Flush:
  - Synchronous; the next state is EMPTY regardless of accept/present in the same cycle.
  - The in_valid entry offered that cycle is discarded (not stored).
  - out_ctrl, out_nop and out_data are cleared to 0.
- Simultaneous nop with stall: nop only affects an entry being accepted; it never modifies a held entry.
- Reset asserted mid-stall or mid-skid: all entries lost, outputs to reset values immediately (asynchronous).
- out_ctrl is 0 whenever out_valid=0.
- Data widths are passed through; no arithmetic.

Optional Feature:
- Macro: PIPE_SKID_EN.
- Defined:
  - Adds a second (skid) entry; state SKID = two entries held.
  - in_ready becomes a registered output equal to "skid slot empty", with no combinational path from out_ready.
  - Transitions:
    - FULL + accept + no present -> SKID.
    - SKID + present -> FULL, with the skid entry moved to the output register.
    - SKID never accepts.
  - Ordering is strictly FIFO.
  - Flush clears both entries.
- Undefined: single-entry behaviour as above, with combinational in_ready; no skid storage is synthesised.

Test Plan:
- Streaming, out_ready=1. Accept ctrl=0x5A, data=0x1234 at edge 1 -> out_valid=1, out_ctrl=0x5A, out_data=0x1234 after edge 1; back-to-back entries appear one per cycle in order.
- Stall. Hold out_ready=0 for 3 cycles with in_valid=1 -> outputs unchanged for all 3 cycles. Without skid: in_ready=0. With skid: one extra entry accepted, then in_ready=0. On release, order is preserved.
- Bubble. nop=1 with in_ctrl=0xFF, data=0xABCD -> out_ctrl=0x00, out_nop=1, out_data=0xABCD. Repeat with in_nop=1 -> same result.
- Flush. Stage FULL (skid: SKID), assert flush with in_valid=1 and ctrl=0x11 -> next cycle out_valid=0, out_ctrl=0, and the 0x11 entry is never presented.
- Async reset. Assert rst mid-stall, between clock edges -> out_valid and out_ctrl go to 0 before the next edge; the first accept after release gives 1-cycle latency.
